// File: rtl/uart_cmd_pkg.sv
// Shared types and byte constants for the UART command parser.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StLen,
    StData,
    StChk,
    StDrain,
    StResp
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_PING  = 8'h00;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

endpackage

// File: rtl/uart_cmd_buf.sv
// Payload buffer: one synchronous write port, one combinational read port.
module uart_cmd_buf #(
  parameter int unsigned Depth = 16,
  parameter int unsigned IdxW  = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic            clock,
  input  logic            we,
  input  logic [IdxW-1:0] waddr,
  input  logic [7:0]      wdata,
  input  logic [IdxW-1:0] raddr,
  output logic [7:0]      rdata
);

  logic [7:0] mem_q [Depth];

  // Contents are don't-care after reset, so no reset on the array.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_cmd_parser.sv
// Framed command parser behind the UART receiver: SYNC CMD ADDR LEN payload CHK.
// Optional inter-byte timeout enabled by defining UART_CMD_PARSER_TIMEOUT_EN.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 2000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        tx_byte,
  output logic [7:0]        err_count,
  output logic              overrun
);

  localparam int unsigned IdxW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MaxLenB = 8'(MAX_LEN);

  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("uart_cmd_parser: parameter out of range");
  end

  state_e            state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        chk_q, chk_d;
  logic [7:0]        idx_q, idx_d;
  logic [7:0]        resp_q, resp_d;
  logic [7:0]        err_q, err_d;
  logic              overrun_q, overrun_d;
  logic              err_inc;
  logic              buf_we;
  logic [7:0]        buf_rdata;
  logic [7:0]        idx_nxt;
  logic              frame_good;

`ifdef UART_CMD_PARSER_TIMEOUT_EN
  localparam int unsigned GapW = $clog2(TIMEOUT_CYCLES + 1);
  logic [GapW-1:0] gap_q, gap_d;
`endif

  uart_cmd_buf #(
    .Depth (MAX_LEN),
    .IdxW  (IdxW)
  ) u_buf (
    .clock (clock),
    .we    (buf_we),
    .waddr (idx_q[IdxW-1:0]),
    .wdata (rx_byte),
    .raddr (idx_q[IdxW-1:0]),
    .rdata (buf_rdata)
  );

  assign idx_nxt    = idx_q + 8'd1;
  assign frame_good = (rx_byte == chk_q) &&
                      ((cmd_q == CMD_WRITE) || ((cmd_q == CMD_PING) && (len_q == 8'd0)));

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    len_d     = len_q;
    chk_d     = chk_q;
    idx_d     = idx_q;
    resp_d    = resp_q;
    overrun_d = overrun_q;
    err_inc   = 1'b0;
    buf_we    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_valid && (rx_byte == SYNC_BYTE)) state_d = StCmd;
      end
      StCmd: begin
        if (rx_valid) begin
          cmd_d   = rx_byte;
          chk_d   = rx_byte;
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (rx_valid) begin
          addr_d  = ADDR_W'(rx_byte);
          chk_d   = chk_q ^ rx_byte;
          state_d = StLen;
        end
      end
      StLen: begin
        if (rx_valid) begin
          len_d = rx_byte;
          chk_d = chk_q ^ rx_byte;
          idx_d = 8'd0;
          if (rx_byte > MaxLenB) begin
            err_inc = 1'b1;
            resp_d  = NAK_BYTE;
            state_d = StResp;
          end else if (rx_byte == 8'd0) begin
            state_d = StChk;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (rx_valid) begin
          buf_we = 1'b1;
          chk_d  = chk_q ^ rx_byte;
          idx_d  = idx_nxt;
          if (idx_nxt == len_q) state_d = StChk;
        end
      end
      StChk: begin
        if (rx_valid) begin
          idx_d = 8'd0;
          if (frame_good && (cmd_q == CMD_WRITE) && (len_q != 8'd0)) begin
            state_d = StDrain;
          end else if (frame_good) begin
            resp_d  = ACK_BYTE;
            state_d = StResp;
          end else begin
            err_inc = 1'b1;
            resp_d  = NAK_BYTE;
            state_d = StResp;
          end
        end
      end
      StDrain: begin
        if (rx_valid) overrun_d = 1'b1;
        if (wr_ready) begin
          idx_d = idx_nxt;
          if (idx_nxt == len_q) begin
            resp_d  = ACK_BYTE;
            state_d = StResp;
          end
        end
      end
      StResp: begin
        if (rx_valid) overrun_d = 1'b1;
        if (tx_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef UART_CMD_PARSER_TIMEOUT_EN
    // Gap counter only runs while a frame is being received.
    gap_d = '0;
    if (state_q inside {StCmd, StAddr, StLen, StData, StChk} && !rx_valid) begin
      gap_d = gap_q + 1'b1;
      if (gap_d == GapW'(TIMEOUT_CYCLES)) begin
        gap_d   = '0;
        err_inc = 1'b1;
        state_d = StIdle;
      end
    end
`endif

    err_d = err_q;
    if (err_inc && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cmd_q     <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      chk_q     <= '0;
      idx_q     <= '0;
      resp_q    <= '0;
      err_q     <= '0;
      overrun_q <= 1'b0;
`ifdef UART_CMD_PARSER_TIMEOUT_EN
      gap_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      chk_q     <= chk_d;
      idx_q     <= idx_d;
      resp_q    <= resp_d;
      err_q     <= err_d;
      overrun_q <= overrun_d;
`ifdef UART_CMD_PARSER_TIMEOUT_EN
      gap_q     <= gap_d;
`endif
    end
  end

  // Write bus is forced to zero outside DRAIN so reset leaves every output at 0.
  assign wr_valid  = (state_q == StDrain);
  assign wr_addr   = wr_valid ? (addr_q + ADDR_W'(idx_q)) : '0;
  assign wr_data   = wr_valid ? buf_rdata : 8'd0;
  assign tx_valid  = (state_q == StResp);
  assign tx_byte   = resp_q;
  assign err_count = err_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits directly downstream of the uart receiver. Consumes its received-byte stream (`rx_byte` plus a one-cycle valid strobe) and parses framed commands.
- Issues byte writes to a register/memory bus and returns a one-byte ACK/NAK, which is fed to the uart transmit side.
- Frame format: SYNC 0xA5, CMD, ADDR, LEN, LEN payload bytes, CHK.
- CHK is the XOR of CMD, ADDR, LEN and every payload byte.

Parameters:
- MAX_LEN, 16, payload buffer depth and largest accepted LEN (1..255).
- ADDR_W, 8, write address width; the ADDR byte is zero-extended or truncated to this width.
- TIMEOUT_CYCLES, 2000, maximum idle clocks between bytes inside a frame (used only with the optional feature).

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- rx_valid  in  1  one-cycle strobe, rx_byte is valid
- rx_byte  in  8  received byte
- wr_valid  out  1  write request
- wr_ready  in  1  write accepted when wr_valid && wr_ready
- wr_addr  out  ADDR_W  write address
- wr_data  out  8  write data
- tx_valid  out  1  response byte valid
- tx_ready  in  1  transmitter accepts when tx_valid && tx_ready
- tx_byte  out  8  response byte
- err_count  out  8  saturating count of rejected frames
- overrun  out  1  sticky; a byte arrived while busy (DRAIN/RESP)

Behaviour:
- Reset (asynchronous, active-low, effective immediately, including mid-frame):
  - state=IDLE; all outputs 0; buffer contents don't-care.
- States: IDLE, CMD, ADDR, LEN, DATA, CHK, DRAIN, RESP. Bytes are consumed only on rx_valid.
- IDLE: byte 0xA5 -> CMD; any other byte is ignored silently (no error).
- CMD: latch cmd, chk=byte -> ADDR.
- ADDR: latch addr, chk^=byte -> LEN.
- LEN: latch len, chk^=byte.
  - len>MAX_LEN -> err_count++, response NAK, -> RESP (frame abandoned).
  - len==0 -> CHK; else -> DATA with idx=0.
- DATA: buf[idx]=byte, chk^=byte, idx++; idx==len -> CHK.
- CHK: the frame is good iff byte==chk and cmd is valid, where valid means cmd==0x01 (write) or (cmd==0x00 (ping) and len==0).
  - Good write with len>0 -> DRAIN.
  - Good ping, or good write with len==0 -> RESP with ACK 0x06.
  - Otherwise -> RESP with NAK 0x15 and err_count++.
- DRAIN: present buf[i] at addr+i, one request per handshake.
  - wr_valid held, with addr/data stable, until wr_ready; then the next entry.
  - Zero-wait bus gives one write per clock.
  - Address wraps modulo 2^ADDR_W.
  - After the last accept -> RESP with ACK.
- RESP: tx_valid=1 with tx_byte held until tx_ready; then -> IDLE.
- Writes never issue before the checksum is verified.
- A byte arriving in DRAIN or RESP is dropped and sets overrun. overrun clears only on reset.
- err_count saturates at 0xFF.
- Same-cycle rx_valid and handshake completion in DRAIN/RESP: the byte is dropped (overrun set); the state advance still occurs.
- Latency:
  - first wr_valid asserts on the clock after the CHK byte strobe;
  - tx_valid asserts the clock after the final write accept, or after the CHK/LEN strobe when there are no writes.

Optional Feature:
- Macro: UART_CMD_PARSER_TIMEOUT_EN.
- With the macro defined:
  - A gap counter resets on every rx_valid while in CMD..CHK.
  - If the counter reaches TIMEOUT_CYCLES -> err_count++, -> IDLE, with no response byte.
  - Inactive in IDLE, DRAIN and RESP.
- Without the macro: no counter is present, and the parser waits indefinitely mid-frame.

Decomposition:
- Package `uart_cmd_pkg`:
  - state enum;
  - constants SYNC_BYTE=0xA5, CMD_PING=0x00, CMD_WRITE=0x01, ACK_BYTE=0x06, NAK_BYTE=0x15.
- Sub-module `uart_cmd_buf`: the MAX_LEN x 8 payload buffer with a write port and a read port. The parser FSM stays in the top module.

Test Plan:
- Write frame A5 01 10 02 AC AD 12 -> writes (0x10,0xAC),(0x11,0xAD); then tx_byte 0x06; err_count 0.
- Same frame with CHK 0x13 -> no wr_valid; tx_byte 0x15; err_count 1.
- Ping frame A5 00 00 00 00 -> tx_byte 0x06, no writes. Leading garbage 0x00 0xFF is ignored.
- LEN 0x11 with MAX_LEN=16 -> NAK right after the LEN byte, err_count++. Subsequent 0xA5 frame parses normally.
- Write at ADDR 0xFF with LEN 2 and wr_ready stalled 3 cycles per beat -> addresses 0xFF then 0x00. Data held stable during the stall. Extra rx byte during the stall sets overrun.
- With UART_CMD_PARSER_TIMEOUT_EN: send A5 01, idle 2000 clocks -> IDLE, err_count 1, no tx. Assert reset_n low mid-DATA -> all outputs 0 immediately.
